binned_blob_stats: RTL and testbench

- Consumes the 1-bit binned mask stream produced by the 4x4 binning stage. Default frame is 320x180 for a 1280x720 source.
- Per frame, accumulates pixel count, x/y coordinate sums and bounding box of set pixels.
- At frame end, runs sequential divides to produce the integer centroid. Publishes one result per frame as a single-cycle pulse for the tracking/overlay logic.

---
 rtl/binned_blob_stats.sv | 259 +++++++++++++++++++++++++
 tb/tb_binned_blob_stats.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/binned_blob_stats.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// binned_blob_stats
//
// Collects per-frame statistics of the set pixels in a binned 1-bit mask
// stream and publishes one result per frame: pixel count, bounding box and
// integer centroid (floor of coordinate sum / count).
//
// The frame ends on the accepted pixel at (HRES-1, VRES-1). One edge after
// that pixel is sampled, the totals are snapshotted into the divider. The
// accumulators restart in the same edge, so the next pixel belongs to the
// new frame. Two restoring dividers (x and y) then run side by side for SXW
// cycles. The result is published with a single-cycle valid_out pulse,
// SXW+2 cycles after the frame-end pixel was sampled.
//
// Ports
//   clk_in, rst_n_in        clock, asynchronous active-low reset
//   hcount_in, vcount_in    binned column / row of the incoming pixel
//   pixel_data_in           mask bit
//   data_valid_in           pixel qualifier (gaps of any length allowed)
//   x_out, y_out            centroid, floor(sum/count)
//   x_min_out .. y_max_out  bounding box of set pixels
//   count_out               number of set pixels in the frame
//   detected_out            count_out >= MIN_PIXELS
//   busy_out                divider running
//   valid_out               one-cycle pulse: all result outputs updated
// -----------------------------------------------------------------------------
module binned_blob_stats #(
  parameter int HRES       = 320,
  parameter int VRES       = 180,
  parameter int MIN_PIXELS = 4,
  localparam int HWIDTH    = $clog2(HRES),
  localparam int VWIDTH    = $clog2(VRES),
  localparam int CWIDTH    = $clog2(HRES*VRES+1),
  localparam int SXW       = HWIDTH + CWIDTH,
  localparam int SYW       = VWIDTH + CWIDTH
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [HWIDTH-1:0] hcount_in,
  input  logic [VWIDTH-1:0] vcount_in,
  input  logic              pixel_data_in,
  input  logic              data_valid_in,
  output logic [HWIDTH-1:0] x_out,
  output logic [VWIDTH-1:0] y_out,
  output logic [HWIDTH-1:0] x_min_out,
  output logic [HWIDTH-1:0] x_max_out,
  output logic [VWIDTH-1:0] y_min_out,
  output logic [VWIDTH-1:0] y_max_out,
  output logic [CWIDTH-1:0] count_out,
  output logic              detected_out,
  output logic              busy_out,
  output logic              valid_out
);

  localparam int STW = $clog2(SXW + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_DONE
  } state_t;

  // ---------------------------------------------------------------------------
  // Accumulation
  // ---------------------------------------------------------------------------
  logic              w_set;
  logic              w_frame_end;

  logic [CWIDTH-1:0] r_cnt;
  logic [SXW-1:0]    r_sum_x;
  logic [SYW-1:0]    r_sum_y;
  logic [HWIDTH-1:0] r_xmin, r_xmax;
  logic [VWIDTH-1:0] r_ymin, r_ymax;
  logic              r_frame_end_d;

  logic [CWIDTH-1:0] w_cnt_base,  w_cnt_nxt;
  logic [SXW-1:0]    w_sx_base,   w_sx_nxt;
  logic [SYW-1:0]    w_sy_base,   w_sy_nxt;
  logic [HWIDTH-1:0] w_xmin_base, w_xmin_nxt, w_xmax_base, w_xmax_nxt;
  logic [VWIDTH-1:0] w_ymin_base, w_ymin_nxt, w_ymax_base, w_ymax_nxt;

  assign w_set       = data_valid_in & pixel_data_in;
  // Out-of-range coordinates are accumulated but can never match here.
  assign w_frame_end = data_valid_in &&
                       (hcount_in == HWIDTH'(HRES - 1)) &&
                       (vcount_in == VWIDTH'(VRES - 1));

  // In the snapshot cycle the old totals are being copied into the divider,
  // so the incoming pixel is added to a cleared base instead.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    w_cnt_base  = r_cnt;
    w_sx_base   = r_sum_x;
    w_sy_base   = r_sum_y;
    w_xmin_base = r_xmin;
    w_xmax_base = r_xmax;
    w_ymin_base = r_ymin;
    w_ymax_base = r_ymax;
    if (r_frame_end_d) begin
      w_cnt_base  = '0;
      w_sx_base   = '0;
      w_sy_base   = '0;
      w_xmin_base = '1;
      w_xmax_base = '0;
      w_ymin_base = '1;
      w_ymax_base = '0;
    end

    w_cnt_nxt  = w_cnt_base;
    w_sx_nxt   = w_sx_base;
    w_sy_nxt   = w_sy_base;
    w_xmin_nxt = w_xmin_base;
    w_xmax_nxt = w_xmax_base;
    w_ymin_nxt = w_ymin_base;
    w_ymax_nxt = w_ymax_base;
    if (w_set) begin
      w_cnt_nxt = w_cnt_base + CWIDTH'(1);
      w_sx_nxt  = w_sx_base + SXW'(hcount_in);
      w_sy_nxt  = w_sy_base + SYW'(vcount_in);
      if (hcount_in < w_xmin_base) w_xmin_nxt = hcount_in;
      if (hcount_in > w_xmax_base) w_xmax_nxt = hcount_in;
      if (vcount_in < w_ymin_base) w_ymin_nxt = vcount_in;
      if (vcount_in > w_ymax_base) w_ymax_nxt = vcount_in;
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_cnt         <= '0;
      r_sum_x       <= '0;
      r_sum_y       <= '0;
      r_xmin        <= '1;
      r_xmax        <= '0;
      r_ymin        <= '1;
      r_ymax        <= '0;
      r_frame_end_d <= 1'b0;
    end else begin
      r_cnt         <= w_cnt_nxt;
      r_sum_x       <= w_sx_nxt;
      r_sum_y       <= w_sy_nxt;
      r_xmin        <= w_xmin_nxt;
      r_xmax        <= w_xmax_nxt;
      r_ymin        <= w_ymin_nxt;
      r_ymax        <= w_ymax_nxt;
      r_frame_end_d <= w_frame_end;
    end
  end

  // ---------------------------------------------------------------------------
  // Divider datapath: one restoring step per cycle for x and y
  // ---------------------------------------------------------------------------
  state_t            r_state;
  logic [STW-1:0]    r_step;
  logic [CWIDTH-1:0] r_div;              // divisor, doubles as count snapshot
  logic [SXW-1:0]    r_quo_x, r_quo_y;   // dividend shifting out, quotient in
  logic [CWIDTH-1:0] r_rem_x, r_rem_y;
  logic [HWIDTH-1:0] r_snap_xmin, r_snap_xmax;
  logic [VWIDTH-1:0] r_snap_ymin, r_snap_ymax;

  logic [CWIDTH:0]   w_rem_x_sh, w_rem_y_sh, w_rem_x_sub, w_rem_y_sub;
  logic              w_ge_x, w_ge_y;
  logic              w_start;

  assign w_rem_x_sh  = {r_rem_x, r_quo_x[SXW-1]};
  assign w_rem_y_sh  = {r_rem_y, r_quo_y[SXW-1]};
  assign w_rem_x_sub = w_rem_x_sh - {1'b0, r_div};
  assign w_rem_y_sub = w_rem_y_sh - {1'b0, r_div};
  assign w_ge_x      = (w_rem_x_sh >= {1'b0, r_div});
  assign w_ge_y      = (w_rem_y_sh >= {1'b0, r_div});

  // A snapshot arriving while the divider runs is dropped.
  assign w_start     = r_frame_end_d && (r_state != S_DIV);

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state      <= S_IDLE;
      r_step       <= '0;
      r_div        <= '0;
      r_quo_x      <= '0;
      r_quo_y      <= '0;
      r_rem_x      <= '0;
      r_rem_y      <= '0;
      r_snap_xmin  <= '0;
      r_snap_xmax  <= '0;
      r_snap_ymin  <= '0;
      r_snap_ymax  <= '0;
      x_out        <= '0;
      y_out        <= '0;
      x_min_out    <= '0;
      x_max_out    <= '0;
      y_min_out    <= '0;
      y_max_out    <= '0;
      count_out    <= '0;
      detected_out <= 1'b0;
      busy_out     <= 1'b0;
      valid_out    <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (w_start) begin
        r_div       <= r_cnt;
        r_quo_x     <= r_sum_x;
        r_quo_y     <= SXW'(r_sum_y);
        r_rem_x     <= '0;
        r_rem_y     <= '0;
        r_step      <= '0;
        r_snap_xmin <= r_xmin;
        r_snap_xmax <= r_xmax;
        r_snap_ymin <= r_ymin;
        r_snap_ymax <= r_ymax;
        busy_out    <= 1'b1;
        r_state     <= S_DIV;
      end else begin
        case (r_state)
          S_DIV: begin
            if (r_step == STW'(SXW)) begin
              // Empty frame: the divide ran only to keep latency fixed.
              if (r_div == '0) begin
                x_out     <= '0;
                y_out     <= '0;
                x_min_out <= '0;
                x_max_out <= '0;
                y_min_out <= '0;
                y_max_out <= '0;
              end else begin
                x_out     <= r_quo_x[HWIDTH-1:0];
                y_out     <= r_quo_y[VWIDTH-1:0];
                x_min_out <= r_snap_xmin;
                x_max_out <= r_snap_xmax;
                y_min_out <= r_snap_ymin;
                y_max_out <= r_snap_ymax;
              end
              count_out    <= r_div;
              detected_out <= (r_div != '0) && (r_div >= CWIDTH'(MIN_PIXELS));
              valid_out    <= 1'b1;
              busy_out     <= 1'b0;
              r_state      <= S_DONE;
            end else begin
              r_rem_x <= w_ge_x ? w_rem_x_sub[CWIDTH-1:0] : w_rem_x_sh[CWIDTH-1:0];
              r_rem_y <= w_ge_y ? w_rem_y_sub[CWIDTH-1:0] : w_rem_y_sh[CWIDTH-1:0];
              r_quo_x <= {r_quo_x[SXW-2:0], w_ge_x};
              r_quo_y <= {r_quo_y[SXW-2:0], w_ge_y};
              r_step  <= r_step + STW'(1);
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_binned_blob_stats.sv
`timescale 1ns/1ps
module tb_binned_blob_stats;

  localparam int P = 10;

  logic clk = 1'b0;
  always #(P/2) clk = ~clk;

  logic rst_n;

  // Default-size instance (320x180)
  logic [8:0]  hcount;
  logic [7:0]  vcount;
  logic        pix, dv;
  logic [8:0]  x_o, xmin_o, xmax_o;
  logic [7:0]  y_o, ymin_o, ymax_o;
  logic [15:0] cnt_o;
  logic        det_o, busy_o, val_o;

  // Small instance (8x2) for the busy-overlap case
  logic [2:0]  s_h;
  logic [0:0]  s_v;
  logic        s_pix, s_dv;
  logic [2:0]  s_x, s_xmin, s_xmax;
  logic [0:0]  s_y, s_ymin, s_ymax;
  logic [4:0]  s_cnt;
  logic        s_det, s_busy, s_val;

  binned_blob_stats dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .hcount_in(hcount), .vcount_in(vcount),
    .pixel_data_in(pix), .data_valid_in(dv),
    .x_out(x_o), .y_out(y_o),
    .x_min_out(xmin_o), .x_max_out(xmax_o),
    .y_min_out(ymin_o), .y_max_out(ymax_o),
    .count_out(cnt_o), .detected_out(det_o),
    .busy_out(busy_o), .valid_out(val_o)
  );

  binned_blob_stats #(.HRES(8), .VRES(2), .MIN_PIXELS(2)) dut_s (
    .clk_in(clk), .rst_n_in(rst_n),
    .hcount_in(s_h), .vcount_in(s_v),
    .pixel_data_in(s_pix), .data_valid_in(s_dv),
    .x_out(s_x), .y_out(s_y),
    .x_min_out(s_xmin), .x_max_out(s_xmax),
    .y_min_out(s_ymin), .y_max_out(s_ymax),
    .count_out(s_cnt), .detected_out(s_det),
    .busy_out(s_busy), .valid_out(s_val)
  );

  typedef struct packed {
    logic [8:0]  x;
    logic [7:0]  y;
    logic [8:0]  xmin;
    logic [8:0]  xmax;
    logic [7:0]  ymin;
    logic [7:0]  ymax;
    logic [15:0] cnt;
    logic        det;
  } res_t;

  int checks   = 0;
  int failures = 0;

  function automatic res_t mk(int x, int y, int xmin, int xmax,
                              int ymin, int ymax, int cnt, bit det);
    res_t r;
    r.x = 9'(x);  r.y = 8'(y);
    r.xmin = 9'(xmin); r.xmax = 9'(xmax);
    r.ymin = 8'(ymin); r.ymax = 8'(ymax);
    r.cnt = 16'(cnt);  r.det = det;
    return r;
  endfunction

  function automatic res_t obs_main();
    res_t r;
    r.x = x_o; r.y = y_o; r.xmin = xmin_o; r.xmax = xmax_o;
    r.ymin = ymin_o; r.ymax = ymax_o; r.cnt = cnt_o; r.det = det_o;
    return r;
  endfunction

  function automatic res_t obs_small();
    res_t r;
    r.x = 9'(s_x); r.y = 8'(s_y); r.xmin = 9'(s_xmin); r.xmax = 9'(s_xmax);
    r.ymin = 8'(s_ymin); r.ymax = 8'(s_ymax); r.cnt = 16'(s_cnt); r.det = s_det;
    return r;
  endfunction

  function automatic string fmt(res_t r);
    return $sformatf("x=%0d y=%0d bbx=%0d..%0d bby=%0d..%0d cnt=%0d det=%0d",
                     r.x, r.y, r.xmin, r.xmax, r.ymin, r.ymax, r.cnt, r.det);
  endfunction

  // Stimulus: inputs change on the falling edge, DUT samples on the rising edge.
  task automatic drive(input int h, input int v, input bit d, input bit vld);
    @(negedge clk);
    hcount = 9'(h); vcount = 8'(v); pix = d; dv = vld;
  endtask

  task automatic send(input int h, input int v, input bit d);
    drive(h, v, d, 1'b1);
  endtask

  task automatic send_s(input int h, input int v, input bit d);
    @(negedge clk);
    s_h = 3'(h); s_v = 1'(v); s_pix = d; s_dv = 1'b1;
  endtask

  // Called right after the frame-end pixel was driven. Iteration k samples
  // just after the k-th rising edge following the one that took that pixel.
  task automatic wait_valid(input bit sel, input int budget,
                            output int lat, output logic busy1);
    lat   = -1;
    busy1 = 1'b0;
    for (int k = 0; k <= budget; k++) begin
      @(negedge clk);
      if (k == 0) begin
        dv   = 1'b0;
        s_dv = 1'b0;
      end
      if (k == 1) busy1 = sel ? s_busy : busy_o;
      if ((sel ? s_val : val_o) === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    hcount = '0; vcount = '0; pix = 1'b0; dv = 1'b0;
    s_h = '0; s_v = '0; s_pix = 1'b0; s_dv = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (obs_main() !== '0 || busy_o !== 1'b0 || val_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_main: got %s busy=%0b valid=%0b, expected all zero",
               fmt(obs_main()), busy_o, val_o);
    end
    checks++;
    if (obs_small() !== '0 || s_busy !== 1'b0 || s_val !== 1'b0) begin
      failures++;
      $display("FAIL reset_small: got %s busy=%0b valid=%0b, expected all zero",
               fmt(obs_small()), s_busy, s_val);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (obs_main() !== '0 || val_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got %s busy=%0b valid=%0b, expected all zero",
               fmt(obs_main()), busy_o, val_o);
    end
  endtask

  task automatic test_single_pixel();
    int lat; logic b1; res_t exp, held;
    send(5, 7, 1'b1);
    send(319, 179, 1'b0);
    wait_valid(1'b0, 60, lat, b1);
    exp = mk(5, 7, 5, 5, 7, 7, 1, 1'b0);
    checks++;
    if (lat != 27) begin
      failures++;
      $display("FAIL single_latency: got %0d, expected 27", lat);
    end
    checks++;
    if (obs_main() !== exp) begin
      failures++;
      $display("FAIL single_result: got %s, expected %s", fmt(obs_main()), fmt(exp));
    end
    checks++;
    if (b1 !== 1'b1) begin
      failures++;
      $display("FAIL single_busy: got %0b, expected 1", b1);
    end
    held = obs_main();
    @(negedge clk);
    checks++;
    if (val_o !== 1'b0 || busy_o !== 1'b0 || obs_main() !== exp) begin
      failures++;
      $display("FAIL single_hold: got valid=%0b busy=%0b %s, expected valid=0 busy=0 %s",
               val_o, busy_o, fmt(obs_main()), fmt(held));
    end
  endtask

  task automatic test_block();
    int lat; logic b1; res_t exp;
    send(10, 20, 1'b1);
    send(11, 20, 1'b1);
    send(10, 21, 1'b1);
    send(11, 21, 1'b1);
    send(319, 179, 1'b0);
    wait_valid(1'b0, 60, lat, b1);
    exp = mk(10, 20, 10, 11, 20, 21, 4, 1'b1);
    checks++;
    if (lat != 27 || obs_main() !== exp) begin
      failures++;
      $display("FAIL block: got lat=%0d %s, expected lat=27 %s", lat, fmt(obs_main()), fmt(exp));
    end
  endtask

  task automatic test_all_ones();
    int lat; logic b1; res_t exp;
    for (int v = 0; v < 180; v++)
      for (int h = 0; h < 320; h++)
        if (!(v == 179 && h == 319)) send(h, v, 1'b1);
    send(319, 179, 1'b1);
    wait_valid(1'b0, 60, lat, b1);
    // sum_x = 180*51040 = 9187200, sum_y = 320*16110 = 5155200, over 57600
    exp = mk(159, 89, 0, 319, 0, 179, 57600, 1'b1);
    checks++;
    if (lat != 27) begin
      failures++;
      $display("FAIL all_ones_latency: got %0d, expected 27", lat);
    end
    checks++;
    if (obs_main() !== exp) begin
      failures++;
      $display("FAIL all_ones_result: got %s, expected %s", fmt(obs_main()), fmt(exp));
    end
  endtask

  task automatic test_zero_then_single();
    int lat; logic b1; res_t exp;
    send(319, 179, 1'b0);
    wait_valid(1'b0, 60, lat, b1);
    checks++;
    if (lat != 27) begin
      failures++;
      $display("FAIL zero_latency: got %0d, expected 27", lat);
    end
    checks++;
    if (obs_main() !== '0) begin
      failures++;
      $display("FAIL zero_result: got %s, expected all zero", fmt(obs_main()));
    end
    send(5, 7, 1'b1);
    send(319, 179, 1'b0);
    wait_valid(1'b0, 60, lat, b1);
    exp = mk(5, 7, 5, 5, 7, 7, 1, 1'b0);
    checks++;
    if (lat != 27 || obs_main() !== exp) begin
      failures++;
      $display("FAIL after_zero: got lat=%0d %s, expected lat=27 %s", lat, fmt(obs_main()), fmt(exp));
    end
  endtask

  task automatic test_out_of_range();
    int lat; logic b1; res_t exp;
    // Neither pixel may end the frame; both still count.
    send(400, 179, 1'b1);
    send(319, 200, 1'b1);
    send(319, 179, 1'b0);
    wait_valid(1'b0, 60, lat, b1);
    exp = mk(359, 189, 319, 400, 179, 200, 2, 1'b0);
    checks++;
    if (lat != 27 || obs_main() !== exp) begin
      failures++;
      $display("FAIL out_of_range: got lat=%0d %s, expected lat=27 %s", lat, fmt(obs_main()), fmt(exp));
    end
  endtask

  task automatic test_random_gaps();
    int lat; logic b1; res_t exp;
    longint sx, sy;
    int cnt, xmn, xmx, ymn, ymx;
    int h, v; bit d, vld;
    sx = 0; sy = 0; cnt = 0; xmn = 1000; xmx = -1; ymn = 1000; ymx = -1;
    for (int i = 0; i < 300; i++) begin
      vld = 1'($urandom_range(0, 1));
      d   = 1'($urandom_range(0, 1));
      h   = $urandom_range(0, 318);
      v   = $urandom_range(0, 179);
      drive(h, v, d, vld);
      if (vld && d) begin
        cnt++; sx += h; sy += v;
        if (h < xmn) xmn = h;
        if (h > xmx) xmx = h;
        if (v < ymn) ymn = v;
        if (v > ymx) ymx = v;
      end
    end
    d = 1'($urandom_range(0, 1));
    send(319, 179, d);
    if (d) begin
      cnt++; sx += 319; sy += 179;
      if (319 < xmn) xmn = 319;
      if (319 > xmx) xmx = 319;
      if (179 < ymn) ymn = 179;
      if (179 > ymx) ymx = 179;
    end
    wait_valid(1'b0, 60, lat, b1);
    if (cnt == 0) exp = '0;
    else exp = mk(int'(sx / cnt), int'(sy / cnt), xmn, xmx, ymn, ymx, cnt, cnt >= 4);
    checks++;
    if (lat != 27) begin
      failures++;
      $display("FAIL random_latency: got %0d, expected 27", lat);
    end
    checks++;
    if (obs_main() !== exp) begin
      failures++;
      $display("FAIL random_result: got %s, expected %s", fmt(obs_main()), fmt(exp));
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic b1; res_t exp; bit extra;
    // Frame A
    send_s(1, 0, 1'b1);
    send_s(3, 1, 1'b1);
    send_s(7, 1, 1'b0);
    // Frame B ends three cycles later, while A is still dividing
    send_s(6, 0, 1'b1);
    send_s(6, 1, 1'b1);
    send_s(7, 1, 1'b1);
    wait_valid(1'b1, 40, lat, b1);
    exp = mk(2, 0, 1, 3, 0, 1, 2, 1'b1);
    checks++;
    if (lat != 7 || obs_small() !== exp) begin
      failures++;
      $display("FAIL overlap_first: got lat=%0d %s, expected lat=7 %s", lat, fmt(obs_small()), fmt(exp));
    end
    checks++;
    if (b1 !== 1'b1) begin
      failures++;
      $display("FAIL overlap_busy: got %0b, expected 1", b1);
    end
    extra = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (s_val === 1'b1) extra = 1'b1;
    end
    checks++;
    if (extra !== 1'b0) begin
      failures++;
      $display("FAIL overlap_dropped: got extra valid=%0b, expected 0", extra);
    end
    // Frame C proves the dropped frame left nothing behind
    send_s(2, 1, 1'b1);
    send_s(7, 1, 1'b0);
    wait_valid(1'b1, 40, lat, b1);
    exp = mk(2, 1, 2, 2, 1, 1, 1, 1'b0);
    checks++;
    if (lat != 10 || obs_small() !== exp) begin
      failures++;
      $display("FAIL overlap_next: got lat=%0d %s, expected lat=10 %s", lat, fmt(obs_small()), fmt(exp));
    end
  endtask

  task automatic test_reset_mid_div();
    int lat; logic b1; res_t exp; bit seen;
    send(5, 7, 1'b1);
    send(319, 179, 1'b0);
    @(negedge clk);
    dv = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (busy_o !== 1'b1) begin
      failures++;
      $display("FAIL middiv_busy: got %0b, expected 1", busy_o);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (obs_main() !== '0 || busy_o !== 1'b0 || val_o !== 1'b0) begin
      failures++;
      $display("FAIL middiv_abort: got %s busy=%0b valid=%0b, expected all zero",
               fmt(obs_main()), busy_o, val_o);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (val_o === 1'b1 || busy_o === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL middiv_quiet: got activity=%0b, expected 0", seen);
    end
    send(100, 50, 1'b1);
    send(101, 51, 1'b1);
    send(103, 50, 1'b1);
    send(319, 179, 1'b0);
    wait_valid(1'b0, 60, lat, b1);
    exp = mk(101, 50, 100, 103, 50, 51, 3, 1'b0);
    checks++;
    if (lat != 27 || obs_main() !== exp) begin
      failures++;
      $display("FAIL middiv_next: got lat=%0d %s, expected lat=27 %s", lat, fmt(obs_main()), fmt(exp));
    end
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_block();
    test_all_ones();
    test_zero_then_single();
    test_out_of_range();
    test_random_gaps();
    test_back_to_back();
    test_reset_mid_div();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
